// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM read/write port controller.
// The lane width is derived from data and mask widths so callers never hard-code 32.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 10;
  localparam int unsigned SRAM_DATA_W = 320;
  localparam int unsigned SRAM_MASK_W = 10;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  function automatic int unsigned lane_width(input int unsigned data_w, input int unsigned mask_w);
    return data_w / mask_w;
  endfunction

  localparam int unsigned SRAM_LANE_W = lane_width(SRAM_DATA_W, SRAM_MASK_W);

endpackage

// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response bus between the cache/queue logic (master) and the port controller (slave).
interface sram_rw_port_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W,
  parameter int unsigned MASK_W = SRAM_MASK_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/sram_resp_fifo.sv
// Two-entry response buffer with a registered head; push and pop in one cycle keep the count.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = SRAM_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] head_r, head_nxt_s;
  logic [DATA_W-1:0] tail_r, tail_nxt_s;
  logic [1:0]        cnt_r, cnt_nxt_s;
  logic              pop_ok_s, push_ok_s;

  // Next-state for head/tail/count; a push into a full buffer without a pop is dropped.
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    cnt_nxt_s  = cnt_r;
    pop_ok_s   = pop && (cnt_r != 2'd0);
    push_ok_s  = push && ((cnt_r != 2'd2) || pop_ok_s);
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        if (cnt_r == 2'd0) begin
          head_nxt_s = push_data;
        end else begin
          tail_nxt_s = push_data;
        end
        cnt_nxt_s = cnt_r + 2'd1;
      end
      2'b01: begin
        head_nxt_s = tail_r;
        cnt_nxt_s  = cnt_r - 2'd1;
      end
      2'b11: begin
        if (cnt_r == 2'd1) begin
          head_nxt_s = push_data;
        end else begin
          head_nxt_s = tail_r;
          tail_nxt_s = push_data;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r <= {DATA_W{1'b0}};
      tail_r <= {DATA_W{1'b0}};
      cnt_r  <= 2'd0;
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign head_data = head_r;
  assign cnt       = cnt_r;

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Owns the single RW port of a masked SRAM macro: zero-fill after reset, then turns a
// valid/ready request stream into macro enables and buffers read data for the consumer.
module sram_rw_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned MASK_W    = SRAM_MASK_W,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  sram_rw_port_ctrl_if.slave  bus,
  output logic                init_done,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [MASK_W-1:0]   sram_wmask,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};
  localparam ctrl_state_e       RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

  ctrl_state_e       state_r, state_nxt_s;
  logic [ADDR_W-1:0] init_cnt_r, init_cnt_nxt_s;
  logic              rd_inflight_r;
  logic [1:0]        fifo_cnt_s;
  logic [2:0]        occupancy_s;
  logic              pop_s, ready_s, accept_s;
  logic              en_s, wmode_s;
  logic [ADDR_W-1:0] addr_s;
  logic [MASK_W-1:0] wmask_s;
  logic [DATA_W-1:0] wdata_s;

  assign bus.resp_valid = (fifo_cnt_s != 2'd0);
  assign pop_s          = bus.resp_valid && bus.resp_ready;

  // A slot leaving the buffer this cycle is credited, so reads stream at one per cycle.
  assign occupancy_s = {1'b0, fifo_cnt_s} + {2'b00, rd_inflight_r} - {2'b00, pop_s};
  assign ready_s     = (state_r == ST_RUN) && (occupancy_s <= 3'd1);
  assign bus.req_ready = ready_s & reset_n;
  assign accept_s      = bus.req_valid && bus.req_ready;

  // Macro drive and FSM next state: zero-fill sweep in INIT, request pass-through in RUN.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    en_s           = 1'b0;
    wmode_s        = 1'b0;
    addr_s         = {ADDR_W{1'b0}};
    wmask_s        = {MASK_W{1'b0}};
    wdata_s        = {DATA_W{1'b0}};
    case (state_r)
      ST_INIT: begin
        en_s    = 1'b1;
        wmode_s = 1'b1;
        addr_s  = init_cnt_r;
        wmask_s = {MASK_W{1'b1}};
        wdata_s = {DATA_W{1'b0}};
        if (init_cnt_r == LAST_ADDR) begin
          state_nxt_s    = ST_RUN;
          init_cnt_nxt_s = {ADDR_W{1'b0}};
        end else begin
          init_cnt_nxt_s = init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          en_s    = 1'b1;
          wmode_s = bus.req_write;
          addr_s  = bus.req_addr;
          wmask_s = bus.req_wmask;
          wdata_s = bus.req_wdata;
        end else begin
          en_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s    = RESET_STATE;
        init_cnt_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, sweep counter and read-in-flight tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= RESET_STATE;
      init_cnt_r    <= {ADDR_W{1'b0}};
      rd_inflight_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      init_cnt_r    <= init_cnt_nxt_s;
      rd_inflight_r <= accept_s && !bus.req_write;
    end
  end

  // Outputs are held quiet while reset is asserted, even though INIT is the reset state.
  assign sram_en    = en_s & reset_n;
  assign sram_wmode = wmode_s;
  assign sram_addr  = addr_s;
  assign sram_wmask = wmask_s;
  assign sram_wdata = wdata_s;
  assign init_done  = (state_r == ST_RUN) & reset_n;

  sram_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_inflight_r),
    .push_data (sram_rdata),
    .pop       (pop_s),
    .head_data (bus.resp_data),
    .cnt       (fifo_cnt_s)
  );

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Randomised and directed bench: macro model plus an in-order reference of outstanding reads.
module tb_sram_rw_port_ctrl;

  localparam int AW = 10;
  localparam int DW = 320;
  localparam int MW = 10;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          init_done, sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata, sram_rdata;

  logic [DW-1:0] mac_mem [1024];
  logic [DW-1:0] ref_mem [1024];
  exp_t          exp_q[$];
  logic [DW-1:0] last_pop;
  int            n_checks = 0, n_errors = 0;
  int            cyc = 0, n_acc = 0, n_pops = 0;

  sram_rw_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  sram_rw_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .INIT_ZERO(1'b1)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clock = ~clock;

  // Masked macro with one-cycle read latency.
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MW; l++)
          if (sram_wmask[l]) mac_mem[sram_addr][l*32 +: 32] <= sram_wdata[l*32 +: 32];
      end else begin
        sram_rdata <= mac_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  endtask

  // Called just after a rising edge; returns just after the rising edge that releases reset.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_outs", {bus.req_ready, bus.resp_valid, init_done, sram_en}, 4'b0000);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic init_check(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid = 1'($urandom % 2);
      bus.req_write = 1'($urandom % 2);
      bus.req_addr  = AW'($urandom);
      bus.resp_ready = 1'($urandom % 2);
      @(negedge clock);
      chk("init_ctl", {sram_en, sram_wmode, sram_addr, sram_wmask, bus.req_ready, init_done, bus.resp_valid},
          {1'b1, 1'b1, i[9:0], 10'h3FF, 1'b0, 1'b0, 1'b0});
      chk("init_wdata", sram_wdata, '0);
      @(posedge clock);
      #1;
    end
  endtask

  // One RUN cycle: drive, compare against the reference, then advance the reference.
  task automatic step(input logic v, input logic w, input logic [AW-1:0] a, input logic [MW-1:0] m,
                      input logic [DW-1:0] d, input logic rr);
    logic exp_vld, exp_pop, exp_rdy, acc;
    int   occ;
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wmask  = m;
    bus.req_wdata  = d;
    bus.resp_ready = rr;
    @(negedge clock);
    exp_vld = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    exp_pop = exp_vld && rr;
    occ     = exp_q.size() - (exp_pop ? 1 : 0);
    exp_rdy = (occ <= 1);
    acc     = v && exp_rdy;
    chk("init_done", init_done, 1'b1);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("resp_valid", bus.resp_valid, exp_vld);
    if (exp_vld) chk("resp_data", bus.resp_data, exp_q[0].data);
    chk("sram_en", sram_en, acc);
    if (acc) chk("sram_cmd", {sram_wmode, sram_addr}, {w, a});
    chk("no_ovf", dut.rd_inflight_r && (dut.fifo_cnt_s == 2'd2), 1'b0);
    if (exp_pop) begin
      last_pop = exp_q[0].data;
      void'(exp_q.pop_front());
      n_pops++;
    end
    if (acc) begin
      n_acc++;
      if (w) begin
        for (int l = 0; l < MW; l++)
          if (m[l]) ref_mem[a][l*32 +: 32] = d[l*32 +: 32];
      end else begin
        exp_q.push_back('{data: ref_mem[a], due: cyc + 2});
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int l = 0; l < MW; l++) d[l*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [DW-1:0] d;
    int base_a, base_p;
    for (int i = 0; i < 1024; i++) mac_mem[i] = rnd_data();
    sram_rdata     = '0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wmask  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    // Reset, partial sweep, reset again mid-INIT, then a full sweep.
    do_reset();
    init_check(100);
    do_reset();
    init_check(1024);

    // Lane-0 write then read-back of the same address.
    d = rnd_data();
    d[31:0] = 32'hDEADBEEF;
    step(1'b1, 1'b1, 10'd5, 10'h001, d, 1'b1);
    step(1'b1, 1'b0, 10'd5, 10'h000, '0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);
    chk("lane0_data", last_pop, {288'h0, 32'hDEADBEEF});

    // Back-to-back reads with the consumer always ready.
    base_a = n_acc;
    base_p = n_pops;
    for (int a = 1; a <= 4; a++) step(1'b1, 1'b0, a[9:0], 10'h000, '0, 1'b1);
    chk("b2b_acc", base_a + 4, n_acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);
    chk("b2b_pops", base_p + 4, n_pops);

    // Back-pressure: only two reads get in, then both drain and accepts resume.
    base_a = n_acc;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'd5, 10'h000, '0, 1'b0);
    chk("bp_acc", base_a + 2, n_acc);
    chk("bp_flags", {bus.req_ready, bus.resp_valid}, 2'b01);
    base_p = n_pops;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);
    chk("bp_drain", base_p + 2, n_pops);
    base_a = n_acc;
    step(1'b1, 1'b0, 10'd2, 10'h000, '0, 1'b1);
    chk("bp_resume", base_a + 1, n_acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);

    // Top-lane write at the last address.
    d = rnd_data();
    d[319:288] = 32'h12345678;
    step(1'b1, 1'b1, 10'h3FF, 10'h200, d, 1'b1);
    step(1'b1, 1'b0, 10'h3FF, 10'h000, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);
    chk("top_lane", last_pop, {32'h12345678, 288'h0});

    // Randomised traffic over a small address set to provoke read-after-write hits.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      a = ($urandom % 4 == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
      step(1'($urandom % 4 != 0), 1'($urandom % 2), a, MW'($urandom), rnd_data(), 1'($urandom % 4 != 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);

    // Reset with one buffered response and one read in flight.
    step(1'b1, 1'b0, 10'd5, 10'h000, '0, 1'b0);
    step(1'b1, 1'b0, 10'h3FF, 10'h000, '0, 1'b0);
    chk("pre_rst_q", exp_q.size(), 2);
    do_reset();
    init_check(1024);
    base_p = n_pops;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);
    chk("no_stale", base_p, n_pops);
    step(1'b1, 1'b0, 10'd5, 10'h000, '0, 1'b1);
    step(1'b1, 1'b0, 10'h3FF, 10'h000, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'd0, 10'h000, '0, 1'b1);
    chk("post_rst_zero", last_pop, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
